axi_wr_rr_arbiter: RTL
======================

// Module: axi_wr_rr_arbiter
// PURPOSE
//  2:1 AXI4 write-path arbiter. Two upstream write masters (S0, S1) share one downstream slave port (M).
//  AW channel: round-robin arbitration. W channel: routed strictly in AW-grant order. B channel: routed back by the source bit prepended to the ID.
//  Sits between two master VIPs/DMA write ports and a single passthrough/slave.
// PARAMETERS
//  ID_W         4    upstream AWID/BID width; downstream ID is ID_W+1 bits
//  ADDR_W       32   address width
//  DATA_W       32   data width; WSTRB is DATA_W/8
//  OUTSTANDING  4    depth of W-order FIFO; power of 2, >=2
//  (derived) AWI_W = ADDR_W+13 = {addr,len[7:0],size[2:0],burst[1:0]}; WP_W = DATA_W+DATA_W/8 = {wdata,wstrb}
// PORTS (s_* packed 2-wide: port n occupies slice n)
//  aclk       in   1             clock
//  aresetn    in   1             async active-low reset
//  s_awid     in   2*ID_W        upstream AWID
//  s_awinfo   in   2*AWI_W       upstream AW payload
//  s_awvalid  in   2             upstream AWVALID
//  s_awready  out  2             upstream AWREADY
//  s_wpld     in   2*WP_W        upstream {WDATA,WSTRB}
//  s_wlast    in   2             upstream WLAST
//  s_wvalid   in   2             upstream WVALID
//  s_wready   out  2             upstream WREADY
//  s_bid      out  ID_W          BID, shared by both ports
//  s_bresp    out  2             BRESP, shared by both ports
//  s_bvalid   out  2             upstream BVALID
//  s_bready   in   2             upstream BREADY
//  m_awid     out  ID_W+1        {src, AWID}
//  m_awinfo   out  AWI_W         downstream AW payload
//  m_awvalid  out  1             downstream AWVALID
//  m_awready  in   1             downstream AWREADY
//  m_wpld     out  WP_W          downstream {WDATA,WSTRB}
//  m_wlast    out  1             downstream WLAST
//  m_wvalid   out  1             downstream WVALID
//  m_wready   in   1             downstream WREADY
//  m_bid      in   ID_W+1        downstream BID
//  m_bresp    in   2             downstream BRESP
//  m_bvalid   in   1             downstream BVALID
//  m_bready   out  1             downstream BREADY
// BEHAVIOUR
//  Reset: aresetn low asynchronously clears m_awvalid, AW regs, FIFO ptrs/count, and sets last_grant=1 (S0 wins first).
//   All valid/ready outputs are 0 during reset. Reset mid-transaction drops all in-flight state; both sides must be reset together.
//  AW slice is a registered single entry, states EMPTY/FULL.
//   load_ok = (EMPTY | m_awready) & !fifo_full.
//   Grant g: if both s_awvalid are set, g = ~last_grant; else the single requester.
//   s_awready[g] = load_ok & s_awvalid[g]; the other port's ready is 0. Ready is combinational; each port's valid drives only its own ready.
//   On an S handshake: latch {g,awid}, awinfo; push g into FIFO; last_grant<=g; m_awvalid=1 next cycle (latency 1).
//   Hold FULL with a stable payload until m_awready. Back-to-back: handshake + load in the same cycle gives 1 AW/cycle.
//  W routing: head = FIFO head when FIFO non-empty.
//   m_wvalid = s_wvalid[head]; s_wready[head] = m_wready; the other port's wready is 0. m_wpld and m_wlast are muxed from head. Zero latency.
//   FIFO empty: m_wvalid=0 and s_wready=0.
//   Pop on m_wvalid & m_wready & m_wlast.
//   W may reach M before the matching AW leaves the slice; downstream must accept W-before-AW per AXI.
//  FIFO: count width clog2(OUTSTANDING)+1. full = (count==OUTSTANDING).
//   Push is gated by full sampled at the start of the cycle: no push while full, even with a simultaneous pop. Push+pop otherwise leaves count unchanged.
//  B: src = m_bid[ID_W]. s_bvalid[src] = m_bvalid, other port 0. m_bready = s_bready[src]. s_bid = m_bid[ID_W-1:0]; s_bresp = m_bresp. Combinational.
//  No ID reordering or interleave: W from an ungranted port stalls until its turn.
// TESTING
//  1 S0 AW id=3 addr=0x100 len=0, 1 W beat -> m_awid=5'h03 one cycle after handshake; B bid=5'h03 -> s_bvalid[0], s_bid=3.
//  2 Both ports post 4 AWs from reset, m_awready=1 -> grant order 0,1,0,1,...; m_awid[ID_W] alternates 0,1.
//  3 S1 AW len=3 granted before S0 AW len=0; S0 W presented first -> s_wready[0]=0 until S1's 4th (WLAST) beat accepted.
//  4 OUTSTANDING=4, m_wready=0, issue 5 AWs -> 5th s_awready stays 0 until one WLAST pop.
//  5 m_awready=0 for 10 cycles with S0 pending -> m_awinfo stable, no further s_awready; release -> 1 handshake.
//  6 aresetn low mid 4-beat burst -> all valids 0 same cycle, FIFO empty; after release S0 granted first.

Source files
------------

// File: rtl/axi_wr_rr_arbiter.sv
// 2:1 AXI4 write-path arbiter: round-robin AW, W routed in AW-grant order,
// B routed back by the source bit carried in the MSB of the downstream ID.
module axi_wr_rr_arbiter #(
  parameter int ID_W        = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int OUTSTANDING = 4,
  localparam int AWI_W      = ADDR_W + 13,
  localparam int WP_W       = DATA_W + DATA_W / 8
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [2*ID_W-1:0]   s_awid,
  input  logic [2*AWI_W-1:0]  s_awinfo,
  input  logic [1:0]          s_awvalid,
  output logic [1:0]          s_awready,
  input  logic [2*WP_W-1:0]   s_wpld,
  input  logic [1:0]          s_wlast,
  input  logic [1:0]          s_wvalid,
  output logic [1:0]          s_wready,
  output logic [ID_W-1:0]     s_bid,
  output logic [1:0]          s_bresp,
  output logic [1:0]          s_bvalid,
  input  logic [1:0]          s_bready,
  output logic [ID_W:0]       m_awid,
  output logic [AWI_W-1:0]    m_awinfo,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [WP_W-1:0]     m_wpld,
  output logic                m_wlast,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic [ID_W:0]       m_bid,
  input  logic [1:0]          m_bresp,
  input  logic                m_bvalid,
  output logic                m_bready
);

  localparam int PTR_W = $clog2(OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  logic               full_q, full_d;
  logic               last_grant_q, last_grant_d;
  logic [ID_W:0]      awid_q, awid_d;
  logic [AWI_W-1:0]   awinfo_q, awinfo_d;
  logic               ord_q [OUTSTANDING];
  logic [PTR_W-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic grant, load_ok, aw_hs, fifo_full, fifo_ne, head, push, pop, bsrc;

  assign grant     = (&s_awvalid) ? ~last_grant_q : s_awvalid[1];
  assign fifo_full = (cnt_q == CNT_W'(OUTSTANDING));
  assign fifo_ne   = (cnt_q != '0);
  // Reset gating keeps every combinational ready low while aresetn is asserted.
  assign load_ok   = (~full_q | m_awready) & ~fifo_full & aresetn;

  always_comb begin
    s_awready        = 2'b00;
    s_awready[grant] = load_ok & s_awvalid[grant];
  end

  assign aw_hs = |s_awready;
  assign push  = aw_hs;

  always_comb begin
    full_d       = full_q;
    last_grant_d = last_grant_q;
    awid_d       = awid_q;
    awinfo_d     = awinfo_q;
    if (aw_hs) begin
      full_d       = 1'b1;
      last_grant_d = grant;
      awid_d       = {grant, grant ? s_awid[2*ID_W-1:ID_W] : s_awid[ID_W-1:0]};
      awinfo_d     = grant ? s_awinfo[2*AWI_W-1:AWI_W] : s_awinfo[AWI_W-1:0];
    end else if (m_awready) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      full_q       <= 1'b0;
      last_grant_q <= 1'b1;
      awid_q       <= '0;
      awinfo_q     <= '0;
    end else begin
      full_q       <= full_d;
      last_grant_q <= last_grant_d;
      awid_q       <= awid_d;
      awinfo_q     <= awinfo_d;
    end
  end

  assign m_awvalid = full_q;
  assign m_awid    = awid_q;
  assign m_awinfo  = awinfo_q;

  // W order FIFO: one source bit per granted AW, popped on the last beat.
  assign head     = ord_q[rptr_q];
  assign m_wvalid = fifo_ne & (head ? s_wvalid[1] : s_wvalid[0]);
  assign s_wready = fifo_ne ? (head ? {m_wready, 1'b0} : {1'b0, m_wready}) : 2'b00;
  assign m_wpld   = head ? s_wpld[2*WP_W-1:WP_W] : s_wpld[WP_W-1:0];
  assign m_wlast  = head ? s_wlast[1] : s_wlast[0];
  assign pop      = m_wvalid & m_wready & m_wlast;

  always_comb begin
    wptr_d = push ? wptr_q + PTR_W'(1) : wptr_q;
    rptr_d = pop  ? rptr_q + PTR_W'(1) : rptr_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (push) ord_q[wptr_q] <= grant;
  end

  assign bsrc     = m_bid[ID_W];
  assign s_bvalid = (aresetn & m_bvalid) ? (bsrc ? 2'b10 : 2'b01) : 2'b00;
  assign m_bready = aresetn & s_bready[bsrc];
  assign s_bid    = m_bid[ID_W-1:0];
  assign s_bresp  = m_bresp;

endmodule
